// File: rtl/m68k_cache_pkg.sv
// Shared state encoding and address-field helpers for the write-through 68k cache controller.
package m68k_cache_pkg;

  typedef enum logic [3:0] {
    ST_RESET           = 4'd0,
    ST_INVALIDATE      = 4'd1,
    ST_IDLE            = 4'd2,
    ST_CHECK_HIT       = 4'd3,
    ST_READ_REQ        = 4'd4,
    ST_CAS_WAIT        = 4'd5,
    ST_BURST_FILL      = 4'd6,
    ST_END_FILL        = 4'd7,
    ST_WRITE_DRAM      = 4'd8,
    ST_WAIT_CACHE_READ = 4'd9
  } cache_state_e;

  function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                           input int unsigned index_bits,
                                           input int unsigned word_bits);
    return addr_bits - index_bits - word_bits - 1;
  endfunction

  // Extract a right-justified field; callers size-cast the result.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] line_base(input logic [63:0] addr,
                                            input int unsigned word_bits);
    return addr & ~((64'd1 << (word_bits + 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/m68k_cache_counter.sv
// Synchronous-clear up-counter shared by the invalidate, CAS-delay and burst phases.
module m68k_cache_counter #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             Clock,
  input  logic             Reset_L,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/m68k_cache_ctrl_wt.sv
// Direct-mapped, write-through (write-update on hit) cache controller between the
// 68000 bus, the tag/data/valid cache RAMs and the Dram controller.
module m68k_cache_ctrl_wt
  import m68k_cache_pkg::*;
#(
  parameter  int unsigned ADDR_BITS   = 32,
  parameter  int unsigned INDEX_BITS  = 9,
  parameter  int unsigned WORD_BITS   = 3,
  parameter  int unsigned CAS_LATENCY = 2,
  localparam int unsigned TAG_BITS    = tag_bits(ADDR_BITS, INDEX_BITS, WORD_BITS)
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic                  Flush_H,
  output logic                  FlushBusy_H,
  input  logic                  CacheHit_H,
  input  logic                  ValidBitIn_H,
  input  logic                  DramSelect68k_H,
  input  logic [ADDR_BITS-1:0]  AddressBusInFrom68k,
  input  logic [15:0]           DataBusInFrom68k,
  output logic [15:0]           DataBusOutTo68k,
  input  logic                  UDS_L,
  input  logic                  LDS_L,
  input  logic                  WE_L,
  input  logic                  AS_L,
  input  logic                  DtackFromDram_L,
  input  logic                  CAS_Dram_L,
  input  logic                  RAS_Dram_L,
  input  logic [15:0]           DataBusInFromDram,
  input  logic [15:0]           DataBusInFromCache,
  output logic [15:0]           DataBusOutToDramController,
  output logic                  UDS_DramController_L,
  output logic                  LDS_DramController_L,
  output logic                  WE_DramController_L,
  output logic                  AS_DramController_L,
  output logic                  DramSelectFromCache_L,
  output logic                  DtackTo68k_L,
  output logic [ADDR_BITS-1:0]  AddressBusOutToDramController,
  output logic                  TagCache_WE_L,
  output logic                  DataCache_WE_L,
  output logic                  ValidBit_WE_L,
  output logic [1:0]            DataCacheByteEn_L,
  output logic                  CacheDataSel_H,
  output logic [TAG_BITS-1:0]   TagDataOut,
  output logic [INDEX_BITS-1:0] Index,
  output logic [WORD_BITS-1:0]  WordAddress,
  output logic                  ValidBitOut_H,
  output logic [3:0]            CacheState
);

  localparam int unsigned      CNT_BITS      = INDEX_BITS + 1;
  localparam logic [CNT_BITS-1:0] INV_DONE   = {1'b1, {INDEX_BITS{1'b0}}};
  localparam logic [CNT_BITS-1:0] BURST_DONE = CNT_BITS'(2 ** WORD_BITS);
  localparam bit               SKIP_CAS_WAIT = (CAS_LATENCY < 2);
  localparam logic [CNT_BITS-1:0] CAS_LAST   = CNT_BITS'(SKIP_CAS_WAIT ? 0 : CAS_LATENCY - 2);

  cache_state_e         state_q, state_d;
  logic                 wr_first_q, wr_first_d;
  logic                 cnt_clr, cnt_inc;
  logic [CNT_BITS-1:0]  cnt;
  logic [INDEX_BITS-1:0] addr_index;
  logic [WORD_BITS-1:0]  addr_word;
  logic [ADDR_BITS-1:0]  line_addr;
  logic                  unused_dram_bus;

  m68k_cache_counter #(
    .WIDTH(CNT_BITS)
  ) u_counter (
    .Clock  (Clock),
    .Reset_L(Reset_L),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .count_o(cnt)
  );

  assign addr_index = INDEX_BITS'(addr_field(64'(AddressBusInFrom68k), WORD_BITS + 1, INDEX_BITS));
  assign addr_word  = WORD_BITS'(addr_field(64'(AddressBusInFrom68k), 1, WORD_BITS));
  assign line_addr  = ADDR_BITS'(line_base(64'(AddressBusInFrom68k), WORD_BITS));
  assign TagDataOut = TAG_BITS'(addr_field(64'(AddressBusInFrom68k),
                                           INDEX_BITS + WORD_BITS + 1, TAG_BITS));

  assign DataBusOutTo68k            = DataBusInFromCache;
  assign DataBusOutToDramController = DataBusInFrom68k;
  assign CacheState                 = state_q;
  assign unused_dram_bus            = ^DataBusInFromDram;

  // The write-update one-shot is armed on the IDLE->WRITE_DRAM transition so the
  // cache RAM is written only in the first cycle of a (possibly long) Dram write.
  assign wr_first_d = (state_q == ST_IDLE) && (state_d == ST_WRITE_DRAM);

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= ST_RESET;
      wr_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_first_q <= wr_first_d;
    end
  end

  always_comb begin
    state_d                       = state_q;
    cnt_clr                       = 1'b0;
    cnt_inc                       = 1'b0;
    FlushBusy_H                   = 1'b0;
    TagCache_WE_L                 = 1'b1;
    DataCache_WE_L                = 1'b1;
    ValidBit_WE_L                 = 1'b1;
    DataCacheByteEn_L             = 2'b11;
    CacheDataSel_H                = 1'b0;
    ValidBitOut_H                 = 1'b0;
    DtackTo68k_L                  = 1'b1;
    DramSelectFromCache_L         = 1'b1;
    UDS_DramController_L          = UDS_L;
    LDS_DramController_L          = LDS_L;
    WE_DramController_L           = WE_L;
    AS_DramController_L           = AS_L;
    AddressBusOutToDramController = line_addr;
    Index                         = addr_index;
    WordAddress                   = addr_word;

    case (state_q)
      ST_RESET: begin
        FlushBusy_H = 1'b1;
        cnt_clr     = 1'b1;
        state_d     = ST_INVALIDATE;
      end

      ST_INVALIDATE: begin
        FlushBusy_H = 1'b1;
        Index       = cnt[INDEX_BITS-1:0];
        if (cnt == INV_DONE) begin
          state_d = ST_IDLE;
        end else begin
          ValidBit_WE_L = 1'b0;
          cnt_inc       = 1'b1;
        end
      end

      ST_IDLE: begin
        if (!AS_L && DramSelect68k_H && WE_L) begin
          state_d = ST_CHECK_HIT;
        end else if (!AS_L && DramSelect68k_H) begin
          DramSelectFromCache_L = 1'b0;
          state_d               = ST_WRITE_DRAM;
        end else if (Flush_H) begin
          cnt_clr = 1'b1;
          state_d = ST_INVALIDATE;
        end
      end

      ST_CHECK_HIT: begin
        UDS_DramController_L = 1'b0;
        LDS_DramController_L = 1'b0;
        if (CacheHit_H && ValidBitIn_H) begin
          DtackTo68k_L = 1'b0;
          state_d      = ST_WAIT_CACHE_READ;
        end else begin
          DramSelectFromCache_L = 1'b0;
          state_d               = ST_READ_REQ;
        end
      end

      ST_WAIT_CACHE_READ: begin
        DtackTo68k_L = 1'b0;
        if (AS_L) begin
          state_d = ST_IDLE;
        end
      end

      ST_READ_REQ: begin
        DramSelectFromCache_L = 1'b0;
        TagCache_WE_L         = 1'b0;
        ValidBit_WE_L         = 1'b0;
        ValidBitOut_H         = 1'b1;
        // A CAS-only cycle is the read data phase; RAS low means refresh.
        if (!CAS_Dram_L && RAS_Dram_L) begin
          cnt_clr = 1'b1;
          state_d = SKIP_CAS_WAIT ? ST_BURST_FILL : ST_CAS_WAIT;
        end
      end

      ST_CAS_WAIT: begin
        DramSelectFromCache_L = 1'b0;
        if (cnt == CAS_LAST) begin
          cnt_clr = 1'b1;
          state_d = ST_BURST_FILL;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      ST_BURST_FILL: begin
        DramSelectFromCache_L = 1'b0;
        if (cnt == BURST_DONE) begin
          state_d = ST_END_FILL;
        end else begin
          DataCache_WE_L    = 1'b0;
          DataCacheByteEn_L = 2'b00;
          WordAddress       = cnt[WORD_BITS-1:0];
          cnt_inc           = 1'b1;
        end
      end

      ST_END_FILL: begin
        DtackTo68k_L = 1'b0;
        if (AS_L || !DramSelect68k_H) begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE_DRAM: begin
        AddressBusOutToDramController = AddressBusInFrom68k;
        DramSelectFromCache_L         = 1'b0;
        DtackTo68k_L                  = DtackFromDram_L;
        if (wr_first_q && CacheHit_H && ValidBitIn_H) begin
          DataCache_WE_L    = 1'b0;
          CacheDataSel_H    = 1'b1;
          DataCacheByteEn_L = {UDS_L, LDS_L};
        end
        if (AS_L || !DramSelect68k_H) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_m68k_cache_ctrl_wt.sv
// Directed bench for m68k_cache_ctrl_wt (INDEX_BITS=4) with queued expectations.
module tb_m68k_cache_ctrl_wt;

  localparam int unsigned AB = 32, IB = 4, WB = 3, CL = 2;
  localparam int unsigned TGB = AB - IB - WB - 1;
  localparam logic [3:0] S_RESET = 4'd0, S_INV = 4'd1, S_IDLE = 4'd2, S_CHK = 4'd3,
                         S_RREQ = 4'd4, S_CASW = 4'd5, S_BURST = 4'd6, S_END = 4'd7,
                         S_WR = 4'd8, S_WAITRD = 4'd9;

  logic           Clock = 1'b0;
  logic           Reset_L, Flush_H, FlushBusy_H, CacheHit_H, ValidBitIn_H, DramSelect68k_H;
  logic [AB-1:0]  AddressBusInFrom68k, AddressBusOutToDramController;
  logic [15:0]    DataBusInFrom68k, DataBusOutTo68k, DataBusInFromDram, DataBusInFromCache;
  logic [15:0]    DataBusOutToDramController;
  logic           UDS_L, LDS_L, WE_L, AS_L, DtackFromDram_L, CAS_Dram_L, RAS_Dram_L;
  logic           UDS_DramController_L, LDS_DramController_L, WE_DramController_L, AS_DramController_L;
  logic           DramSelectFromCache_L, DtackTo68k_L, TagCache_WE_L, DataCache_WE_L, ValidBit_WE_L;
  logic [1:0]     DataCacheByteEn_L;
  logic           CacheDataSel_H, ValidBitOut_H;
  logic [TGB-1:0] TagDataOut;
  logic [IB-1:0]  Index;
  logic [WB-1:0]  WordAddress;
  logic [3:0]     CacheState;

  int checks = 0;
  int failures = 0;
  int unsigned inv_q[$];
  int unsigned burst_q[$];

  m68k_cache_ctrl_wt #(
    .ADDR_BITS(AB), .INDEX_BITS(IB), .WORD_BITS(WB), .CAS_LATENCY(CL)
  ) dut (
    .Clock(Clock), .Reset_L(Reset_L), .Flush_H(Flush_H), .FlushBusy_H(FlushBusy_H),
    .CacheHit_H(CacheHit_H), .ValidBitIn_H(ValidBitIn_H), .DramSelect68k_H(DramSelect68k_H),
    .AddressBusInFrom68k(AddressBusInFrom68k), .DataBusInFrom68k(DataBusInFrom68k),
    .DataBusOutTo68k(DataBusOutTo68k), .UDS_L(UDS_L), .LDS_L(LDS_L), .WE_L(WE_L), .AS_L(AS_L),
    .DtackFromDram_L(DtackFromDram_L), .CAS_Dram_L(CAS_Dram_L), .RAS_Dram_L(RAS_Dram_L),
    .DataBusInFromDram(DataBusInFromDram), .DataBusInFromCache(DataBusInFromCache),
    .DataBusOutToDramController(DataBusOutToDramController),
    .UDS_DramController_L(UDS_DramController_L), .LDS_DramController_L(LDS_DramController_L),
    .WE_DramController_L(WE_DramController_L), .AS_DramController_L(AS_DramController_L),
    .DramSelectFromCache_L(DramSelectFromCache_L), .DtackTo68k_L(DtackTo68k_L),
    .AddressBusOutToDramController(AddressBusOutToDramController),
    .TagCache_WE_L(TagCache_WE_L), .DataCache_WE_L(DataCache_WE_L), .ValidBit_WE_L(ValidBit_WE_L),
    .DataCacheByteEn_L(DataCacheByteEn_L), .CacheDataSel_H(CacheDataSel_H),
    .TagDataOut(TagDataOut), .Index(Index), .WordAddress(WordAddress),
    .ValidBitOut_H(ValidBitOut_H), .CacheState(CacheState)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  // Steps cycles until CacheState reaches target, popping queued expectations
  // for every invalidate pulse and every burst-fill pulse seen on the way.
  task automatic sweep(input logic [3:0] target, input int unsigned budget, input string tag,
                       output int unsigned first_burst);
    bit reached = 1'b0;
    int unsigned e;
    first_burst = 0;
    for (int unsigned k = 1; k <= budget; k++) begin
      tick(); #1;
      if (ValidBit_WE_L === 1'b0 && ValidBitOut_H === 1'b0) begin
        chk({tag, "_inv_pending"}, 32'(inv_q.size() != 0), 32'd1);
        if (inv_q.size() != 0) begin
          e = inv_q.pop_front();
          chk({tag, "_inv_index"}, 32'(Index), e);
        end
        chk({tag, "_inv_busy"}, 32'(FlushBusy_H), 32'd1);
      end
      if (DataCache_WE_L === 1'b0 && CacheDataSel_H === 1'b0) begin
        if (first_burst == 0) first_burst = k;
        chk({tag, "_burst_pending"}, 32'(burst_q.size() != 0), 32'd1);
        if (burst_q.size() != 0) begin
          e = burst_q.pop_front();
          chk({tag, "_burst_word"}, 32'(WordAddress), e);
        end
        chk({tag, "_burst_byteen"}, 32'(DataCacheByteEn_L), 32'd0);
      end
      if (CacheState === target) begin
        reached = 1'b1;
        break;
      end
    end
    chk({tag, "_reached"}, 32'(reached), 32'd1);
  endtask

  initial begin
    int unsigned fb;
    bit sel_low;
    int unsigned pulses;

    Reset_L = 1'b0; Flush_H = 1'b0; CacheHit_H = 1'b0; ValidBitIn_H = 1'b0;
    DramSelect68k_H = 1'b0; AddressBusInFrom68k = '0; DataBusInFrom68k = 16'h0;
    UDS_L = 1'b1; LDS_L = 1'b1; WE_L = 1'b1; AS_L = 1'b1; DtackFromDram_L = 1'b1;
    CAS_Dram_L = 1'b1; RAS_Dram_L = 1'b1; DataBusInFromDram = 16'hBEEF;
    DataBusInFromCache = 16'h1234;

    #12;
    chk("rst_state", 32'(CacheState), 32'(S_RESET));
    chk("rst_busy", 32'(FlushBusy_H), 32'd1);
    chk("rst_valid_we", 32'(ValidBit_WE_L), 32'd1);
    chk("rst_tag_we", 32'(TagCache_WE_L), 32'd1);
    chk("rst_data_we", 32'(DataCache_WE_L), 32'd1);
    chk("rst_dtack", 32'(DtackTo68k_L), 32'd1);
    chk("rst_sel", 32'(DramSelectFromCache_L), 32'd1);
    chk("rst_cache_data", 32'(DataBusOutTo68k), 32'h1234);

    tick(); Reset_L = 1'b1; #1;
    for (int unsigned i = 0; i < 16; i++) inv_q.push_back(i);
    sweep(S_IDLE, 40, "init", fb);
    chk("init_inv_left", 32'(inv_q.size()), 32'd0);
    chk("init_idle_busy", 32'(FlushBusy_H), 32'd0);

    // Read miss at 0x136 with a byte strobe pattern (UDS high) and a refresh in READ_REQ.
    tick();
    AddressBusInFrom68k = 32'h136; DramSelect68k_H = 1'b1; WE_L = 1'b1;
    UDS_L = 1'b1; LDS_L = 1'b0; AS_L = 1'b0; #1;
    chk("rm_idle_dramaddr", AddressBusOutToDramController, 32'h130);
    chk("rm_idle_uds_follow", 32'(UDS_DramController_L), 32'd1);
    tick(); #1;
    chk("rm_chk_state", 32'(CacheState), 32'(S_CHK));
    chk("rm_chk_sel", 32'(DramSelectFromCache_L), 32'd0);
    chk("rm_chk_uds_forced", 32'(UDS_DramController_L), 32'd0);
    chk("rm_tag", 32'(TagDataOut), 32'h1);
    chk("rm_index", 32'(Index), 32'd3);
    tick(); CAS_Dram_L = 1'b0; RAS_Dram_L = 1'b0; #1;
    chk("rm_rreq_state", 32'(CacheState), 32'(S_RREQ));
    chk("rm_rreq_tag_we", 32'(TagCache_WE_L), 32'd0);
    chk("rm_rreq_valid_we", 32'(ValidBit_WE_L), 32'd0);
    chk("rm_rreq_valid_out", 32'(ValidBitOut_H), 32'd1);
    tick(); CAS_Dram_L = 1'b1; RAS_Dram_L = 1'b1; #1;
    chk("rm_refresh_ignored", 32'(CacheState), 32'(S_RREQ));
    tick(); CAS_Dram_L = 1'b0; RAS_Dram_L = 1'b1; Flush_H = 1'b1; #1;
    for (int unsigned w = 0; w < 8; w++) burst_q.push_back(w);
    sweep(S_END, 20, "rm_fill", fb);
    CAS_Dram_L = 1'b1;
    chk("rm_cas_latency", fb, CL);
    chk("rm_fill_left", 32'(burst_q.size()), 32'd0);
    chk("rm_end_dtack", 32'(DtackTo68k_L), 32'd0);
    chk("rm_end_word", 32'(WordAddress), 32'd3);
    chk("rm_end_sel", 32'(DramSelectFromCache_L), 32'd1);

    // Flush raised during the read must wait for AS_L high.
    tick(); #1;
    chk("fl_hold_end", 32'(CacheState), 32'(S_END));
    chk("fl_hold_busy", 32'(FlushBusy_H), 32'd0);
    tick(); AS_L = 1'b1; DramSelect68k_H = 1'b0; UDS_L = 1'b1; LDS_L = 1'b1; #1;
    tick(); #1;
    chk("fl_idle_first", 32'(CacheState), 32'(S_IDLE));
    for (int unsigned i = 0; i < 16; i++) inv_q.push_back(i);
    sweep(S_IDLE, 40, "flush", fb);
    Flush_H = 1'b0;
    chk("flush_inv_left", 32'(inv_q.size()), 32'd0);
    tick(); #1;
    chk("flush_done_idle", 32'(CacheState), 32'(S_IDLE));

    // Read hit: served from the cache, Dram never selected.
    tick();
    AddressBusInFrom68k = 32'h136; DramSelect68k_H = 1'b1; WE_L = 1'b1;
    UDS_L = 1'b0; LDS_L = 1'b0; AS_L = 1'b0; CacheHit_H = 1'b1; ValidBitIn_H = 1'b1; #1;
    sel_low = (DramSelectFromCache_L === 1'b0);
    chk("hr_idle_dtack", 32'(DtackTo68k_L), 32'd1);
    tick(); #1;
    sel_low |= (DramSelectFromCache_L === 1'b0);
    chk("hr_chk_dtack", 32'(DtackTo68k_L), 32'd0);
    tick(); #1;
    sel_low |= (DramSelectFromCache_L === 1'b0);
    chk("hr_wait_state", 32'(CacheState), 32'(S_WAITRD));
    chk("hr_wait_dtack", 32'(DtackTo68k_L), 32'd0);
    chk("hr_wait_word", 32'(WordAddress), 32'd3);
    tick(); AS_L = 1'b1; DramSelect68k_H = 1'b0; #1;
    sel_low |= (DramSelectFromCache_L === 1'b0);
    tick(); #1;
    chk("hr_back_idle", 32'(CacheState), 32'(S_IDLE));
    chk("hr_sel_never_low", 32'(sel_low), 32'd0);

    // Upper-byte write hit: one cache update, Dtack tracks the Dram controller.
    tick();
    AddressBusInFrom68k = 32'h13A; DataBusInFrom68k = 16'hA55A; DramSelect68k_H = 1'b1;
    WE_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b1; AS_L = 1'b0; DtackFromDram_L = 1'b1; #1;
    pulses = 0;
    chk("bw_idle_sel", 32'(DramSelectFromCache_L), 32'd0);
    chk("bw_idle_dramaddr", AddressBusOutToDramController, 32'h130);
    tick(); #1;
    pulses += (DataCache_WE_L === 1'b0) ? 1 : 0;
    chk("bw_state", 32'(CacheState), 32'(S_WR));
    chk("bw_byteen", 32'(DataCacheByteEn_L), 32'b01);
    chk("bw_datasel", 32'(CacheDataSel_H), 32'd1);
    chk("bw_full_addr", AddressBusOutToDramController, 32'h13A);
    chk("bw_dram_data", 32'(DataBusOutToDramController), 32'hA55A);
    chk("bw_dtack_wait", 32'(DtackTo68k_L), 32'd1);
    tick(); DtackFromDram_L = 1'b0; #1;
    pulses += (DataCache_WE_L === 1'b0) ? 1 : 0;
    chk("bw_dtack_follow", 32'(DtackTo68k_L), 32'd0);
    tick(); AS_L = 1'b1; DramSelect68k_H = 1'b0; DtackFromDram_L = 1'b1;
    WE_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; #1;
    pulses += (DataCache_WE_L === 1'b0) ? 1 : 0;
    tick(); #1;
    chk("bw_back_idle", 32'(CacheState), 32'(S_IDLE));
    chk("bw_pulses", pulses, 32'd1);

    // Reset pulsed in the middle of a burst fill.
    tick();
    AddressBusInFrom68k = 32'h200; CacheHit_H = 1'b0; ValidBitIn_H = 1'b0;
    DramSelect68k_H = 1'b1; WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0; AS_L = 1'b0; #1;
    tick(); #1;
    chk("rb_chk_state", 32'(CacheState), 32'(S_CHK));
    tick(); CAS_Dram_L = 1'b0; RAS_Dram_L = 1'b1; #1;
    tick(); CAS_Dram_L = 1'b1; #1;
    tick(); #1;
    chk("rb_burst_state", 32'(CacheState), 32'(S_BURST));
    chk("rb_burst_we", 32'(DataCache_WE_L), 32'd0);
    Reset_L = 1'b0; #1;
    chk("rb_rst_state", 32'(CacheState), 32'(S_RESET));
    chk("rb_rst_data_we", 32'(DataCache_WE_L), 32'd1);
    chk("rb_rst_tag_we", 32'(TagCache_WE_L), 32'd1);
    chk("rb_rst_valid_we", 32'(ValidBit_WE_L), 32'd1);
    chk("rb_rst_busy", 32'(FlushBusy_H), 32'd1);
    tick(); Reset_L = 1'b1; AS_L = 1'b1; DramSelect68k_H = 1'b0; UDS_L = 1'b1; LDS_L = 1'b1; #1;
    for (int unsigned i = 0; i < 16; i++) inv_q.push_back(i);
    sweep(S_IDLE, 40, "rb_inv", fb);
    chk("rb_inv_left", 32'(inv_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
